pgm_loader: RTL and testbench
=============================

// Module: pgm_loader
// PURPOSE
//  Writer side of the program memory that fetch/decode read as DM_data_pgm.
//  Accepts a framed byte stream on a valid/ready input and writes it into program memory from address 0.
//  Holds the core (fetch/decode stall) while loading. Releases it only after a verified checksum.
//  Frame: SYNC, LEN (0 = 256), LEN data bytes, CSUM, where (sum of data + CSUM) mod 256 == 0.
// PARAMETERS
//  SYNC_BYTE  8'hA5  frame start marker, recognised only in IDLE
//  TIMEOUT    50000  max cycles between accepted bytes inside a frame; must be >= 1
// PORTS
//  sig_clk        in   1  clock, all state on rising edge
//  sig_rst_n      in   1  asynchronous, active-low reset
//  in_data        in   8  stream byte
//  in_valid       in   1  in_data valid
//  in_ready       out  1  loader can accept; a byte transfers when in_valid & in_ready
//  PM_addr_wr     out  8  program memory write address
//  PM_data_wr     out  8  program memory write data
//  PM_sig_we      out  1  program memory write enable, 1 cycle per byte
//  sig_core_hold  out  1  stall core fetch/decode while high
//  sig_load_done  out  1  1-cycle pulse on successful load
//  sig_load_err   out  1  sticky error; cleared when the next SYNC is accepted
//  sig_busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset values: FSM=IDLE, in_ready=1, PM_addr_wr=0, PM_data_wr=0, PM_sig_we=0.
//  Reset values (cont.): sig_core_hold=0, sig_load_done=0, sig_load_err=0, sig_busy=0.
//  Counters cleared at reset: 9-bit remaining count, 8-bit address counter, 8-bit checksum accumulator, timeout counter.
//  States: IDLE -> LEN -> DATA -> CSUM -> CHECK -> IDLE.
//  IDLE: in_ready=1. Non-SYNC bytes are discarded with no writes.
//   On accepting SYNC: sig_load_err<=0, sig_core_hold<=1 (visible next cycle), go to LEN.
//  LEN: accepting byte L sets remaining = (L==0) ? 256 : L, addr=0, acc=0; go to DATA.
//  DATA: in_ready=1 (no backpressure). Each accepted byte b:
//   - next cycle: PM_sig_we=1, PM_addr_wr=addr, PM_data_wr=b
//   - then acc<=acc+b (mod 256), addr<=addr+1 (mod 256), remaining<=remaining-1
//   - when remaining reaches 0, go to CSUM. SYNC_BYTE here is ordinary data.
//  CSUM: accepting byte c stores it; go to CHECK.
//  CHECK (1 cycle, in_ready=0):
//   - if (acc+c) mod 256 == 0: next cycle sig_load_done=1 for 1 cycle and sig_core_hold=0
//   - else: sig_load_err=1 and sig_core_hold stays 1 (memory partially overwritten)
//   - both cases return to IDLE.
//  Timeout: counter runs in LEN/DATA/CSUM and clears on every accepted byte.
//   On reaching TIMEOUT: sig_load_err=1, hold stays 1, go to IDLE; any write already issued completes.
//   Byte accepted in the same cycle the timeout would fire: the byte wins and the counter clears.
//  PM_sig_we is 0 in every cycle without a DATA write. The write latency is exactly 1 cycle after acceptance.
//  A new SYNC after an error restarts a load. Only a successful CHECK deasserts hold.
//  sig_rst_n low at any time, including mid-frame: all outputs go to reset values immediately (async).
//   Hold drops to 0, so the system must reload. The next frame writes from address 0.
// TESTING
//  1. A5 03 11 22 33 9A -> writes (00,11) (01,22) (02,33), done pulse once, hold 1->0, err 0.
//  2. A5 03 11 22 33 9B -> same three writes, err=1, no done, hold stays 1; follow with test 1 frame -> err 0, hold 0.
//  3. A5 00, data 00..FF, CSUM 80 -> 256 writes, addr 00..FF with no overrun, done pulse.
//  4. 00 FF 5A 11 then test 1 frame -> garbage produces no writes and busy stays 0 until A5; then test 1 response.
//  5. TIMEOUT=100: A5 03 11 22, then idle -> err=1 exactly 100 cycles after the 22 accept, FSM IDLE, hold 1.
//  6. Random in_valid gaps on test 1 frame, and sig_rst_n pulsed mid-DATA -> outputs at reset values.
//     After reset, a fresh frame writes starting at address 00.

Source files
------------

// File: rtl/pgm_loader_if.sv
// Byte stream channel into the program loader: valid/ready handshake carrying one byte per transfer.
interface pgm_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pgm_loader.sv
// Program memory loader: receives SYNC/LEN/data/CSUM frames and writes them from address 0.
// The core is held stalled from SYNC until a verified checksum releases it.
module pgm_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic         sig_clk,
    input  logic         sig_rst_n,
    pgm_loader_if.slave  in_s,
    output logic [7:0]   PM_addr_wr,
    output logic [7:0]   PM_data_wr,
    output logic         PM_sig_we,
    output logic         sig_core_hold,
    output logic         sig_load_done,
    output logic         sig_load_err,
    output logic         sig_busy
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_CHECK} state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic [7:0]    pm_addr_q, pm_data_q;
    logic          pm_we_q, hold_q, done_q, err_q, busy_q;
    logic [8:0]    rem_q;
    logic [7:0]    addr_q, acc_q, csum_q;
    logic [TW-1:0] tmo_q;
    logic          accept;

    assign accept        = in_s.in_valid & in_ready_q;
    assign in_s.in_ready = in_ready_q;
    assign PM_addr_wr    = pm_addr_q;
    assign PM_data_wr    = pm_data_q;
    assign PM_sig_we     = pm_we_q;
    assign sig_core_hold = hold_q;
    assign sig_load_done = done_q;
    assign sig_load_err  = err_q;
    assign sig_busy      = busy_q;

    always_ff @(posedge sig_clk or negedge sig_rst_n) begin
        if (!sig_rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            pm_addr_q  <= '0;
            pm_data_q  <= '0;
            pm_we_q    <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rem_q      <= '0;
            addr_q     <= '0;
            acc_q      <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
        end else begin
            pm_we_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept && in_s.in_data == SYNC_BYTE) begin
                        err_q   <= 1'b0;
                        hold_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_LEN;
                    end
                end
                S_LEN, S_DATA, S_CSUM: begin
                    // An accepted byte always beats a timeout firing on the same edge.
                    if (!accept) begin
                        if (tmo_q == TMO_LAST) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            tmo_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end else begin
                        tmo_q <= '0;
                        unique case (state_q)
                            S_LEN: begin
                                rem_q   <= (in_s.in_data == 8'd0) ? 9'd256 : {1'b0, in_s.in_data};
                                addr_q  <= '0;
                                acc_q   <= '0;
                                state_q <= S_DATA;
                            end
                            S_DATA: begin
                                pm_we_q   <= 1'b1;
                                pm_addr_q <= addr_q;
                                pm_data_q <= in_s.in_data;
                                acc_q     <= acc_q + in_s.in_data;
                                addr_q    <= addr_q + 8'd1;
                                rem_q     <= rem_q - 9'd1;
                                if (rem_q == 9'd1) state_q <= S_CSUM;
                            end
                            default: begin
                                csum_q     <= in_s.in_data;
                                in_ready_q <= 1'b0;
                                state_q    <= S_CHECK;
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (8'(acc_q + csum_q) == 8'd0) begin
                        done_q <= 1'b1;
                        hold_q <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pgm_loader.sv
// Directed bench for pgm_loader: expected writes are queued by stimulus and popped by a write monitor.
module tb_pgm_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pgm_loader_if ifc();
    logic [7:0] pm_addr, pm_data;
    logic       pm_we, hold, done, err, busy;

    pgm_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(100)) dut (
        .sig_clk       (clk),
        .sig_rst_n     (rst_n),
        .in_s          (ifc.slave),
        .PM_addr_wr    (pm_addr),
        .PM_data_wr    (pm_data),
        .PM_sig_we     (pm_we),
        .sig_core_hold (hold),
        .sig_load_done (done),
        .sig_load_err  (err),
        .sig_busy      (busy)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    bit          rnd_gap = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    logic [7:0]  fbuf [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pm_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", pm_addr, pm_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pm_write", {16'd0, pm_addr, pm_data}, {16'd0, mon_e});
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] b);
        int k;
        if (rnd_gap) repeat ($urandom_range(0, 4)) @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        k = 0;
        while (ifc.in_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_wait: got no in_ready in 200 cycles, expected ready");
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input logic [7:0] a);
        exp_q.push_back({a, b});
        send(b);
    endtask

    task automatic frame(input int len, input logic [7:0] cs, input bit ok);
        int d0;
        d0 = done_cnt;
        send(8'hA5);
        chk("hold_after_sync", hold, 1);
        chk("busy_after_sync", busy, 1);
        chk("err_cleared_by_sync", err, 0);
        send(8'(len));
        for (int i = 0; i < len; i++) send_data(fbuf[i], 8'(i));
        send(cs);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - d0, ok ? 1 : 0);
        chk("hold_after_frame", hold, ok ? 0 : 1);
        chk("err_after_frame", err, ok ? 0 : 1);
        chk("busy_after_frame", busy, 0);
        chk("writes_outstanding", exp_q.size(), 0);
    endtask

    task automatic load_t1;
        fbuf[0] = 8'h11; fbuf[1] = 8'h22; fbuf[2] = 8'h33;
    endtask

    initial begin
        int c;
        logic [7:0] garbage [4];
        garbage = '{8'h00, 8'hFF, 8'h5A, 8'h11};
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", ifc.in_ready, 1);
        chk("rst_outs", {pm_addr, pm_data, pm_we, hold, done, err, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: good 3-byte frame; 2: bad checksum then good frame
        load_t1(); frame(3, 8'h9A, 1'b1);
        load_t1(); frame(3, 8'h9B, 1'b0);
        load_t1(); frame(3, 8'h9A, 1'b1);

        // 3: LEN 0 means 256 bytes, addresses 00..FF
        for (int i = 0; i < 256; i++) fbuf[i] = 8'(i);
        frame(256, 8'h80, 1'b1);

        // 4: garbage in IDLE is dropped without writes or busy
        foreach (garbage[i]) begin
            send(garbage[i]);
            chk("garbage_busy", busy, 0);
            chk("garbage_hold", hold, 0);
        end
        load_t1(); frame(3, 8'h9A, 1'b1);

        // 5: stall mid-data, timeout fires 100 cycles after the last accept
        send(8'hA5); send(8'h03);
        send_data(8'h11, 8'h00); send_data(8'h22, 8'h01);
        c = 0;
        while (err !== 1'b1 && c < 150) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_cycles", c, 100);
        chk("timeout_busy", busy, 0);
        chk("timeout_hold", hold, 1);
        chk("timeout_ready", ifc.in_ready, 1);

        // 6: random valid gaps, then async reset mid-DATA, then a fresh load
        rnd_gap = 1'b1;
        load_t1(); frame(3, 8'h9A, 1'b1);
        rnd_gap = 1'b0;
        send(8'hA5); send(8'h03);
        send_data(8'h11, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_ready", ifc.in_ready, 1);
        chk("midreset_outs", {pm_addr, pm_data, pm_we, hold, done, err, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fbuf[0] = 8'h01; fbuf[1] = 8'h02; fbuf[2] = 8'hFD;
        frame(3, 8'h00, 1'b1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
